l2_assoc_cache: RTL and testbench

// - Parametrised N-way set-associative L2 data store. Successor of the single-word L2 array.
// - Adds a req/resp handshake with backpressure, true-LRU replacement (evicts when a set is full),
//   in-place write hits and a whole-cache flush sequencer.
// - Sits between the L1 controller (requester) and the memory-side logic.
// - Miss data is not fetched here; the requester refills by issuing a write.

---
 rtl/l2_assoc_cache_if.sv | 38 +++
 rtl/l2_assoc_cache.sv | 184 ++++++++++++++++++
 tb/tb_l2_assoc_cache.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_assoc_cache_if.sv
// ============================================================================
// Module   : l2_assoc_cache_if
// Purpose  : Request/response bus between the L1 controller and the L2 store.
//            The requester (master) presents req_* and accepts resp_*; the
//            cache (slave) answers with req_ready and the registered response.
// Ports    : req_valid/req_ready/req_wr/req_addr/req_data  request channel
//            resp_valid/resp_ready/resp_hit/resp_evict/resp_data  response
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface l2_assoc_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic              resp_evict;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_evict, resp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_evict, resp_data
  );
endinterface

`default_nettype wire

// File: rtl/l2_assoc_cache.sv
// ============================================================================
// Module   : l2_assoc_cache
// Purpose  : N-way set-associative L2 data store with true-LRU replacement,
//            req/resp handshake with backpressure and a whole-cache flush.
//            Misses are not refilled here; the requester refills with a write.
// Ports    : clk, rst_n (async active-low), bus (l2_assoc_cache_if.slave),
//            flush (start flush, sampled in IDLE), busy (not IDLE),
//            hit_count/miss_count (only with CACHE_STATS_EN defined).
// Config   : CACHE_STATS_EN - adds saturating 32-bit hit/miss counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_assoc_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int SETS   = 16,
  parameter int WAYS   = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  l2_assoc_cache_if.slave     bus,
  input  wire                 flush,
`ifdef CACHE_STATS_EN
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
`endif
  output logic                busy
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int AGE_W   = $clog2(WAYS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_FLUSH} state_t;
  state_t r_state, w_next;

  logic [WAYS-1:0]    r_valid    [SETS];
  logic [AGE_W-1:0]   r_age      [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag_arr  [SETS][WAYS];
  logic [DATA_W-1:0]  r_data_arr [SETS][WAYS];

  logic               r_req_wr;
  logic [TAG_W-1:0]   r_req_tag;
  logic [INDEX_W-1:0] r_req_idx;
  logic [DATA_W-1:0]  r_req_data;
  logic [INDEX_W-1:0] r_flush_set;

  logic               r_resp_valid, r_resp_hit, r_resp_evict;
  logic [DATA_W-1:0]  r_resp_data;

  logic               w_hit, w_free, w_accept;
  logic [AGE_W-1:0]   w_hit_way, w_free_way, w_lru_way, w_touch;

  // Address bits below the index carry no meaning for this block.
  logic w_unused_addr;
  assign w_unused_addr = ^bus.req_addr[ADDR_W-TAG_W-INDEX_W-1:0];

  assign bus.req_ready  = (r_state == S_IDLE) && !flush;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_evict = r_resp_evict;
  assign bus.resp_data  = r_resp_data;
  assign busy           = (r_state != S_IDLE);
  assign w_accept       = bus.req_valid && bus.req_ready;

  // Way selection for the indexed set. Descending loops make the lowest
  // matching/free way win.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    w_lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[r_req_idx][w] && (r_tag_arr[r_req_idx][w] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!r_valid[r_req_idx][w]) begin
        w_free     = 1'b1;
        w_free_way = AGE_W'(w);
      end
      if (r_age[r_req_idx][w] == AGE_W'(WAYS - 1)) begin
        w_lru_way = AGE_W'(w);
      end
    end
    w_touch = w_hit ? w_hit_way : (w_free ? w_free_way : w_lru_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (flush) w_next = S_FLUSH;
                else if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = S_RESP;
      S_RESP:   if (bus.resp_ready) w_next = S_IDLE;
      S_FLUSH:  if (r_flush_set == INDEX_W'(SETS - 1)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control state: valid bits, ages, captured request and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
      r_req_wr     <= 1'b0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_req_data   <= '0;
      r_flush_set  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_evict <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_flush_set <= '0;
          if (w_accept) begin
            r_req_wr   <= bus.req_wr;
            r_req_tag  <= bus.req_addr[ADDR_W-1 -: TAG_W];
            r_req_idx  <= bus.req_addr[ADDR_W-TAG_W-1 -: INDEX_W];
            r_req_data <= bus.req_data;
          end
        end
        S_LOOKUP: begin
          r_resp_valid <= 1'b1;
          r_resp_hit   <= w_hit;
          r_resp_evict <= r_req_wr && !w_hit && !w_free;
          r_resp_data  <= r_req_wr ? r_req_data :
                          (w_hit ? r_data_arr[r_req_idx][w_hit_way] : '0);
          if (w_hit || r_req_wr) begin
            r_valid[r_req_idx][w_touch] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (r_age[r_req_idx][w] < r_age[r_req_idx][w_touch])
                r_age[r_req_idx][w] <= r_age[r_req_idx][w] + 1'b1;
            end
            r_age[r_req_idx][w_touch] <= '0;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) r_resp_valid <= 1'b0;
        end
        S_FLUSH: begin
          r_valid[r_flush_set] <= '0;
          for (int w = 0; w < WAYS; w++) r_age[r_flush_set][w] <= AGE_W'(w);
          r_flush_set <= r_flush_set + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays are never cleared; only valid bits gate them.
  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP && r_req_wr) begin
      r_tag_arr[r_req_idx][w_touch]  <= r_req_tag;
      r_data_arr[r_req_idx][w_touch] <= r_req_data;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && hit_count != 32'hFFFF_FFFF)         hit_count  <= hit_count + 1'b1;
      else if (!w_hit && miss_count != 32'hFFFF_FFFF)  miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_assoc_cache.sv
// ============================================================================
// Module   : tb_l2_assoc_cache
// Purpose  : Directed self-checking bench for l2_assoc_cache (default params:
//            tag = addr[31:28], index = addr[27:24]).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l2_assoc_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  l2_assoc_cache_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  l2_assoc_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .flush      (flush),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request with resp_ready held high. lat = edges from the edge that
  // accepts the request until resp_valid is observed (accept edge counts 1).
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic hit, output logic evict, output logic [31:0] rd,
                     output int lat);
    int n;
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_wr    = wr;
    bif.req_addr  = addr;
    bif.req_data  = data;
    n = 0;
    while (!bif.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    lat = 1;
    while (!bif.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bif.resp_valid) check("resp_timeout", 64'd0, 64'd1);
    hit   = bif.resp_hit;
    evict = bif.resp_evict;
    rd    = bif.resp_data;
    @(posedge clk);
    #1;
  endtask

  logic        h, e;
  logic [31:0] d, held;
  int          lat, cnt, rdy_cnt;

  initial begin
    bif.req_valid  = 1'b0;
    bif.req_wr     = 1'b0;
    bif.req_addr   = '0;
    bif.req_data   = '0;
    bif.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready",  {63'd0, bif.req_ready},  64'd1);
    check("rst_busy",       {63'd0, busy},           64'd0);
    check("rst_resp_valid", {63'd0, bif.resp_valid}, 64'd0);
    check("rst_resp_hit",   {63'd0, bif.resp_hit},   64'd0);
    check("rst_resp_evict", {63'd0, bif.resp_evict}, 64'd0);
    check("rst_resp_data",  {32'd0, bif.resp_data},  64'd0);

    // Cold read misses; response appears on the second edge after presentation.
    txn(1'b0, 32'h1000_0000, 32'h0, h, e, d, lat);
    check("cold_rd_hit",   {63'd0, h}, 64'd0);
    check("cold_rd_evict", {63'd0, e}, 64'd0);
    check("cold_rd_data",  {32'd0, d}, 64'd0);
    check("cold_rd_lat",   64'(lat),   64'd2);

    txn(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, h, e, d, lat);
    check("wr1_hit",   {63'd0, h}, 64'd0);
    check("wr1_evict", {63'd0, e}, 64'd0);
    check("wr1_data",  {32'd0, d}, 64'h0000_0000_DEAD_BEEF);
    txn(1'b0, 32'h1000_0000, 32'h0, h, e, d, lat);
    check("rd1_hit",  {63'd0, h}, 64'd1);
    check("rd1_data", {32'd0, d}, 64'h0000_0000_DEAD_BEEF);
    txn(1'b0, 32'h1100_0000, 32'h0, h, e, d, lat);
    check("rd_idx1_hit", {63'd0, h}, 64'd0);

    // LRU eviction: fill set 0 with tag0..3, touch tag0, tag1 becomes LRU.
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      txn(1'b1, 32'(t) << 28, 32'(t), h, e, d, lat);
      check("fill_evict", {63'd0, e}, 64'd0);
    end
    txn(1'b0, 32'h0000_0000, 32'h0, h, e, d, lat);
    check("lru_rd0_hit", {63'd0, h}, 64'd1);
    txn(1'b1, 32'h4000_0000, 32'h44, h, e, d, lat);
    check("lru_wr4_hit",   {63'd0, h}, 64'd0);
    check("lru_wr4_evict", {63'd0, e}, 64'd1);
    txn(1'b0, 32'h1000_0000, 32'h0, h, e, d, lat);
    check("lru_rd1_hit",  {63'd0, h}, 64'd0);
    check("lru_rd1_data", {32'd0, d}, 64'd0);
    txn(1'b0, 32'h0000_0000, 32'h0, h, e, d, lat);
    check("lru_rd0b_hit",  {63'd0, h}, 64'd1);
    check("lru_rd0b_data", {32'd0, d}, 64'd0);
    txn(1'b0, 32'h4000_0000, 32'h0, h, e, d, lat);
    check("lru_rd4_hit",  {63'd0, h}, 64'd1);
    check("lru_rd4_data", {32'd0, d}, 64'h44);

    // In-place write hit.
    txn(1'b1, 32'h2000_0000, 32'h11, h, e, d, lat);
    txn(1'b1, 32'h2000_0000, 32'h22, h, e, d, lat);
    check("wrhit_hit",   {63'd0, h}, 64'd1);
    check("wrhit_evict", {63'd0, e}, 64'd0);
    txn(1'b0, 32'h2000_0000, 32'h0, h, e, d, lat);
    check("wrhit_rd", {32'd0, d}, 64'h22);

    // Backpressure: response held stable for 5 cycles with resp_ready low.
    @(negedge clk);
    bif.resp_ready = 1'b0;
    bif.req_valid  = 1'b1;
    bif.req_wr     = 1'b0;
    bif.req_addr   = 32'h4000_0000;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    cnt = 0;
    while (!bif.resp_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    held = bif.resp_data;
    check("bp_first_data", {32'd0, held}, 64'h44);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {63'd0, bif.resp_valid}, 64'd1);
      check("bp_data",  {32'd0, bif.resp_data},  {32'd0, held});
      check("bp_hit",   {63'd0, bif.resp_hit},   64'd1);
      check("bp_ready", {63'd0, bif.req_ready},  64'd0);
    end
    @(negedge clk);
    bif.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_valid", {63'd0, bif.resp_valid}, 64'd0);
    check("bp_rel_busy",  {63'd0, busy},           64'd0);

    // Flush: busy and req_ready low for exactly SETS cycles.
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_ready_comb", {63'd0, bif.req_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cnt = 0;
    rdy_cnt = 0;
    while (busy && cnt < 40) begin
      if (bif.req_ready) rdy_cnt++;
      cnt++;
      @(posedge clk);
      #1;
    end
    check("flush_cycles", 64'(cnt),     64'd16);
    check("flush_ready",  64'(rdy_cnt), 64'd0);
    txn(1'b0, 32'h0000_0000, 32'h0, h, e, d, lat);
    check("post_flush_rd0", {63'd0, h}, 64'd0);
    txn(1'b0, 32'h4000_0000, 32'h0, h, e, d, lat);
    check("post_flush_rd4", {63'd0, h}, 64'd0);
    txn(1'b0, 32'h2000_0000, 32'h0, h, e, d, lat);
    check("post_flush_rd2", {63'd0, h}, 64'd0);
    check("post_flush_dat", {32'd0, d}, 64'd0);

    // Reset asserted mid-flush takes effect immediately.
    txn(1'b1, 32'h3500_0000, 32'h77, h, e, d, lat);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midflush_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  {63'd0, busy},           64'd0);
    check("midrst_ready", {63'd0, bif.req_ready},  64'd1);
    check("midrst_valid", {63'd0, bif.resp_valid}, 64'd0);
    check("midrst_data",  {32'd0, bif.resp_data},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 32'h3500_0000, 32'h0, h, e, d, lat);
    check("after_rst_rd", {63'd0, h}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
